// File: rtl/pc_sequencer.sv
// pc_sequencer: MIPS fetch-stage program counter with jump/JR/branch redirect.
// Optional macro DELAY_SLOT_EN: when defined, a redirect first fetches one
// delay-slot instruction (SEQ/SLOT FSM) before the target is applied. When
// undefined, an accepted redirect loads the target directly into pc_out.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        jump,
  input  logic [25:0] instr_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        branch,
  input  logic [15:0] branch_offset,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        in_slot,
  output logic        misalign,
  output logic        redirect_dropped
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned OFFW = 16;
  localparam int unsigned SEXW = XLEN - OFFW - 2;

  logic [XLEN-1:0] r_pc;
  logic            r_misalign;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_jump_target;
  logic [XLEN-1:0] w_branch_target;
  logic [XLEN-1:0] w_jr_target;
  logic [XLEN-1:0] w_target;
  logic            w_req;
  logic            w_jr_misaligned;

  // Sequential address; depends on pc_out only, wraps mod 2^32.
  assign w_pc_plus4 = r_pc + XLEN'(4);

  // Redirect targets. The jump region comes from PC+4, not PC.
  assign w_jump_target   = {w_pc_plus4[31:28], instr_index, 2'b00};
  assign w_branch_target = w_pc_plus4 + {{SEXW{branch_offset[OFFW-1]}}, branch_offset, 2'b00};
  assign w_jr_target     = {jr_target[31:2], 2'b00};
  assign w_req           = jr | jump | branch;
  assign w_jr_misaligned = jr & (jr_target[1:0] != 2'b00);

  // Priority select of the redirect target: jr > jump > branch.
  always_comb begin
    w_target = w_branch_target;
    if (jr) begin
      w_target = w_jr_target;
    end else if (jump) begin
      w_target = w_jump_target;
    end
  end

  assign pc_out   = r_pc;
  assign pc_plus4 = w_pc_plus4;
  assign misalign = r_misalign;

`ifdef DELAY_SLOT_EN
  typedef enum logic {
    ST_SEQ  = 1'b0,
    ST_SLOT = 1'b1
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pending_target;
  logic            r_in_slot;
  logic            r_redirect_dropped;

  // Delay-slot FSM: a request in SEQ fetches the slot, then SLOT applies the target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc               <= RESET_PC;
      r_state            <= ST_SEQ;
      r_pending_target   <= '0;
      r_in_slot          <= 1'b0;
      r_misalign         <= 1'b0;
      r_redirect_dropped <= 1'b0;
    end else begin
      r_misalign         <= 1'b0;
      r_redirect_dropped <= 1'b0;
      if (!stall) begin
        case (r_state)
          ST_SEQ: begin
            r_pc <= w_pc_plus4;
            if (w_req) begin
              r_pending_target <= w_target;
              r_state          <= ST_SLOT;
              r_in_slot        <= 1'b1;
              r_misalign       <= w_jr_misaligned;
            end
          end
          ST_SLOT: begin
            r_pc               <= r_pending_target;
            r_state            <= ST_SEQ;
            r_in_slot          <= 1'b0;
            r_redirect_dropped <= w_req;
          end
        endcase
      end
    end
  end

  assign in_slot          = r_in_slot;
  assign redirect_dropped = r_redirect_dropped;
`else
  // Direct redirect: an accepted request loads the target on the sampling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      if (!stall) begin
        r_pc       <= w_req ? w_target : w_pc_plus4;
        r_misalign <= w_jr_misaligned;
      end
    end
  end

  assign in_slot          = 1'b0;
  assign redirect_dropped = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven bench for pc_sequencer with an expected-value scoreboard queue.
// Expectations follow DELAY_SLOT_EN the same way the design does.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        jump;
  logic [25:0] instr_index;
  logic        jr;
  logic [31:0] jr_target;
  logic        branch;
  logic [15:0] branch_offset;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        in_slot;
  logic        misalign;
  logic        redirect_dropped;

  pc_sequencer #(.RESET_PC(32'h0040_0000)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .jump             (jump),
    .instr_index      (instr_index),
    .jr               (jr),
    .jr_target        (jr_target),
    .branch           (branch),
    .branch_offset    (branch_offset),
    .pc_out           (pc_out),
    .pc_plus4         (pc_plus4),
    .in_slot          (in_slot),
    .misalign         (misalign),
    .redirect_dropped (redirect_dropped)
  );

  typedef struct {
    logic        stall;
    logic        jump;
    logic [25:0] idx;
    logic        jr;
    logic [31:0] jrt;
    logic        branch;
    logic [15:0] off;
    logic [31:0] exp_pc;
    logic        exp_slot;
    logic        exp_mis;
    logic        exp_drop;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        slot;
    logic        mis;
    logic        drop;
  } exp_t;

  vec_t vecs[40];
  int   nvec;
  exp_t sb[$];
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual timeout, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic st, input logic j, input logic [25:0] ix,
                     input logic r, input logic [31:0] rt, input logic b,
                     input logic [15:0] of, input logic [31:0] pc,
                     input logic sl, input logic mi, input logic dr);
    vecs[nvec] = '{st, j, ix, r, rt, b, of, pc, sl, mi, dr};
    nvec++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Compare all outputs against one expected record.
  task automatic compare(input exp_t e);
    chk({e.name, ".pc_out"}, pc_out, e.pc);
    chk({e.name, ".pc_plus4"}, pc_plus4, e.pc + 32'd4);
    chk({e.name, ".in_slot"}, 32'(in_slot), 32'(e.slot));
    chk({e.name, ".misalign"}, 32'(misalign), 32'(e.mis));
    chk({e.name, ".dropped"}, 32'(redirect_dropped), 32'(e.drop));
  endtask

  task automatic drive(input vec_t v);
    stall         = v.stall;
    jump          = v.jump;
    instr_index   = v.idx;
    jr            = v.jr;
    jr_target     = v.jrt;
    branch        = v.branch;
    branch_offset = v.off;
  endtask

  // Drive one vector, queue its expectation, and compare after the edge.
  task automatic step(input string name, input vec_t v);
    exp_t e;
    drive(v);
    e = '{name, v.exp_pc, v.exp_slot, v.exp_mis, v.exp_drop};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, actual 0 entries, required 1", name);
    end else begin
      compare(sb.pop_front());
    end
  endtask

  task automatic check_reset(input string name);
    exp_t e;
    e = '{name, 32'h0040_0000, 1'b0, 1'b0, 1'b0};
    compare(e);
  endtask

  vec_t idle;

  initial begin
    checks = 0;
    errors = 0;
    nvec   = 0;
    idle   = '{1'b0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0};

    // stall jump idx jr jr_target branch offset -> pc slot mis drop
    add(0,0,26'h0,      0,32'h0,        0,16'h0,    32'h0040_0004,0,0,0);
    add(0,0,26'h0,      0,32'h0,        0,16'h0,    32'h0040_0008,0,0,0);
    add(0,0,26'h0,      0,32'h0,        0,16'h0,    32'h0040_000C,0,0,0);
`ifdef DELAY_SLOT_EN
    add(0,1,26'h0100010,0,32'h0,        0,16'h0,    32'h0040_0010,1,0,0);
    add(0,0,26'h0,      0,32'h0,        0,16'h0,    32'h0040_0040,0,0,0);
    add(0,0,26'h0,      1,32'h0040_0103,1,16'hFFFF, 32'h0040_0044,1,1,0);
    add(0,0,26'h0,      0,32'h0,        0,16'h0,    32'h0040_0100,0,0,0);
    add(0,0,26'h0,      0,32'h0,        1,16'hFFFF, 32'h0040_0104,1,0,0);
    add(0,1,26'h0000100,0,32'h0,        0,16'h0,    32'h0040_0100,0,0,1);
    add(0,0,26'h0,      0,32'h0,        0,16'h0,    32'h0040_0104,0,0,0);
    add(0,0,26'h0,      0,32'h0,        1,16'h0010, 32'h0040_0108,1,0,0);
    add(1,0,26'h0,      0,32'h0,        0,16'h0,    32'h0040_0108,1,0,0);
    add(1,0,26'h0,      1,32'h0000_0003,0,16'h0,    32'h0040_0108,1,0,0);
    add(1,0,26'h0,      0,32'h0,        0,16'h0,    32'h0040_0108,1,0,0);
    add(0,0,26'h0,      0,32'h0,        0,16'h0,    32'h0040_0148,0,0,0);
    add(0,0,26'h0,      1,32'hFFFF_FFFC,0,16'h0,    32'h0040_014C,1,0,0);
    add(0,0,26'h0,      0,32'h0,        0,16'h0,    32'hFFFF_FFFC,0,0,0);
    add(0,1,26'h3FFFFFF,0,32'h0,        0,16'h0,    32'h0000_0000,1,0,0);
    add(0,0,26'h0,      0,32'h0,        0,16'h0,    32'h0FFF_FFFC,0,0,0);
    add(0,0,26'h0,      1,32'h0000_0200,0,16'h0,    32'h1000_0000,1,0,0);
    add(0,0,26'h0,      1,32'h0000_0003,0,16'h0,    32'h0000_0200,0,0,1);
`else
    add(0,1,26'h0100010,0,32'h0,        0,16'h0,    32'h0040_0040,0,0,0);
    add(0,0,26'h0,      1,32'h0040_0103,1,16'hFFFF, 32'h0040_0100,0,1,0);
    add(0,0,26'h0,      0,32'h0,        1,16'hFFFF, 32'h0040_0100,0,0,0);
    add(0,0,26'h0,      0,32'h0,        0,16'h0,    32'h0040_0104,0,0,0);
    add(0,1,26'h0000100,0,32'h0,        1,16'h0010, 32'h0000_0400,0,0,0);
    add(0,0,26'h0,      0,32'h0,        1,16'h0010, 32'h0000_0444,0,0,0);
    add(1,1,26'h0000100,0,32'h0,        0,16'h0,    32'h0000_0444,0,0,0);
    add(1,0,26'h0,      1,32'h0000_0003,0,16'h0,    32'h0000_0444,0,0,0);
    add(0,0,26'h0,      1,32'hFFFF_FFFC,0,16'h0,    32'hFFFF_FFFC,0,0,0);
    add(0,1,26'h3FFFFFF,0,32'h0,        0,16'h0,    32'h0FFF_FFFC,0,0,0);
    add(0,0,26'h0,      1,32'hFFFF_FFFF,0,16'h0,    32'hFFFF_FFFC,0,1,0);
    add(0,0,26'h0,      0,32'h0,        0,16'h0,    32'h0000_0000,0,0,0);
    add(0,0,26'h0,      1,32'hFFFF_FFFC,0,16'h0,    32'hFFFF_FFFC,0,0,0);
    add(0,1,26'h0000000,0,32'h0,        0,16'h0,    32'h0000_0000,0,0,0);
`endif

    // Reset state.
    rst_n = 1'b0;
    drive(idle);
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;

    for (int i = 0; i < nvec; i++) begin
      step($sformatf("v%0d", i), vecs[i]);
    end

    // Mid-run asynchronous reset returns pc_out to RESET_PC without an edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Request right after reset, then reset before the target is applied.
    begin
      vec_t v;
      v = idle;
      v.jump = 1'b1;
      v.idx  = 26'h0100010;
`ifdef DELAY_SLOT_EN
      v.exp_pc   = 32'h0040_0004;
      v.exp_slot = 1'b1;
`else
      v.exp_pc   = 32'h0040_0040;
`endif
      step("jump_then_reset", v);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset("reset_in_slot");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      v = idle;
      v.exp_pc = 32'h0040_0004;
      step("after_reset", v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
